// File: rtl/read_response_buffer_if.sv
// Read-response buffer bus: fabric push side, user pop side,
// occupancy/status back to the read master.
interface read_response_buffer_if #(
  parameter int DATAWIDTH      = 32,
  parameter int FIFODEPTH_LOG2 = 5
);
  logic                      control_go;
  logic [DATAWIDTH-1:0]      master_readdata;
  logic                      master_readdatavalid;
  logic [FIFODEPTH_LOG2-1:0] fifo_used;
  logic                      user_read_buffer;
  logic [DATAWIDTH-1:0]      user_buffer_data;
  logic                      user_data_available;
  logic                      fifo_full;
  logic [31:0]               words_received;
  logic                      overflow_error;
  logic                      underflow_error;

  modport slave (
    input  control_go, master_readdata,
    input  master_readdatavalid, user_read_buffer,
    output fifo_used, user_buffer_data,
    output user_data_available, fifo_full,
    output words_received, overflow_error,
    output underflow_error
  );

  modport master (
    output control_go, master_readdata,
    output master_readdatavalid, user_read_buffer,
    input  fifo_used, user_buffer_data,
    input  user_data_available, fifo_full,
    input  words_received, overflow_error,
    input  underflow_error
  );
endinterface

// File: rtl/read_response_buffer.sv
// Show-ahead read-data FIFO behind the read master, with occupancy
// feedback, receive counter and sticky overflow/underflow flags.
module read_response_buffer #(
  parameter int DATAWIDTH      = 32,
  parameter int FIFODEPTH      = 32,
  parameter int FIFODEPTH_LOG2 = 5
) (
  input logic clk,
  input logic reset_n,
  read_response_buffer_if.slave bus
);
  localparam int CW = FIFODEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFODEPTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [FIFODEPTH_LOG2-1:0] P_ONE =
    FIFODEPTH_LOG2'(1);
  localparam logic [FIFODEPTH_LOG2-1:0] USED_MAX =
    FIFODEPTH_LOG2'(FIFODEPTH - 1);

  logic [DATAWIDTH-1:0]      mem_q [FIFODEPTH];
  logic [FIFODEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFODEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [31:0]               wrc_q, wrc_d;
  logic                      ovf_q, ovf_d;
  logic                      unf_q, unf_d;
  logic                      push, pop, full_eff;

  // A pop frees the slot the same edge, so full push+pop is legal.
  assign pop      = bus.user_read_buffer & (count_q != '0);
  assign full_eff = (count_q == DEPTH) & ~pop;
  assign push     = bus.master_readdatavalid & ~full_eff;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wrc_d    = bus.control_go ? '0 : wrc_q;
    ovf_d    = bus.control_go ? 1'b0 : ovf_q;
    unf_d    = bus.control_go ? 1'b0 : unf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + P_ONE;
      wrc_d    = wrc_d + 32'd1;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + P_ONE;
    unique case (1'b1)
      push & ~pop: count_d = count_q + C_ONE;
      pop & ~push: count_d = count_q - C_ONE;
      default:     count_d = count_q;
    endcase
    if (bus.master_readdatavalid & full_eff)
      ovf_d = 1'b1;
    if (bus.user_read_buffer & (count_q == '0))
      unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFODEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wrc_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (push)
        mem_q[wr_ptr_q] <= bus.master_readdata;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wrc_q    <= wrc_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.user_buffer_data    = mem_q[rd_ptr_q];
  assign bus.user_data_available = (count_q != '0);
  assign bus.fifo_full           = (count_q == DEPTH);
  assign bus.fifo_used = (count_q >= DEPTH) ? USED_MAX
                       : count_q[FIFODEPTH_LOG2-1:0];
  assign bus.words_received      = wrc_q;
  assign bus.overflow_error      = ovf_q;
  assign bus.underflow_error     = unf_q;
endmodule
